bram_port_arbiter: RTL and testbench

Shares one simple-dual-port block RAM between two requesters: m0 (CPU bus bridge) and m1 (DMA/accelerator engine). The RAM has a byte-enabled write port A and a read port B with registered output. The arbiter drives each RAM port from at most one master per cycle. A write from one master and a read from the other can proceed in the same cycle on the separate ports. It also enforces write-before-read ordering on address collisions and returns read data with a valid strobe.

---
 rtl/bram_port_arbiter_if.sv | 48 ++++
 rtl/bram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Request/response and RAM-port bundle for bram_port_arbiter.
// The master modport is the environment side: the two requesters plus the
// RAM, which supplies bram_doutb. The slave modport is the arbiter.
interface bram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  m0_req;
  logic                  m0_we;
  logic [3:0]            m0_be;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [31:0]           m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [31:0]           m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [3:0]            m1_be;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [31:0]           m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [31:0]           m1_rdata;

  logic [ADDR_WIDTH-1:0] bram_addra;
  logic [31:0]           bram_dina;
  logic [3:0]            bram_wea;
  logic [ADDR_WIDTH-1:0] bram_addrb;
  logic [31:0]           bram_doutb;

  modport master (
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  bram_addra, bram_dina, bram_wea, bram_addrb,
    output bram_doutb
  );

  modport slave (
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output bram_addra, bram_dina, bram_wea, bram_addrb,
    input  bram_doutb
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-master arbiter for a simple-dual-port BRAM (write port A, registered
// read port B). Writes and reads are arbitrated independently so a write
// from one master and a read from the other share a cycle. A read that hits
// the address being written in the same cycle is held one cycle so it sees
// the new data (the RAM returns old data on a same-cycle collision).

// Per-master slice: request classification and read-return qualification.
module bram_port_arbiter_lane #(
  parameter logic IDX = 1'b0
) (
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  rd_owner,
  input  logic [31:0] doutb,
  output logic        wr_req,
  output logic        rd_req,
  output logic        rvalid,
  output logic [31:0] rdata
);
  assign wr_req = req & we;
  assign rd_req = req & ~we;
  // rd_owner[0] = read in flight, rd_owner[1] = owning master
  assign rvalid = rd_owner[0] & (rd_owner[1] == IDX);
  // Data is shared; only rvalid says whose it is
  assign rdata  = doutb;
endmodule

module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int PRIO_MODE  = 0
) (
  input logic                HCLK,
  input logic                HRESETn,
  bram_port_arbiter_if.slave bus
);
  localparam int  NM    = 2;
  localparam bit  FIXED = (PRIO_MODE != 0);

  logic [NM-1:0]                 req, we, wr_req, rd_req, rvalid;
  logic [NM-1:0]                 wr_gnt, rd_gnt;
  logic [NM-1:0][3:0]            be;
  logic [NM-1:0][ADDR_WIDTH-1:0] addr;
  logic [NM-1:0][31:0]           wdata, rdata;

  // Pointer value 0 selects m0, 1 selects m1
  logic       wr_prio, rd_prio;
  logic [1:0] rd_owner;

  logic wr_any, rd_any, wr_sel, rd_sel, collide, rd_go;

  assign req   = {bus.m1_req,   bus.m0_req};
  assign we    = {bus.m1_we,    bus.m0_we};
  assign be    = {bus.m1_be,    bus.m0_be};
  assign addr  = {bus.m1_addr,  bus.m0_addr};
  assign wdata = {bus.m1_wdata, bus.m0_wdata};

  for (genvar i = 0; i < NM; i++) begin : g_lane
    bram_port_arbiter_lane #(.IDX(i[0])) u_lane (
      .req      (req[i]),
      .we       (we[i]),
      .rd_owner (rd_owner),
      .doutb    (bus.bram_doutb),
      .wr_req   (wr_req[i]),
      .rd_req   (rd_req[i]),
      .rvalid   (rvalid[i]),
      .rdata    (rdata[i])
    );
  end

  // Pick one winner per RAM port and hold a read that collides with the write
  always_comb begin
    wr_any = |wr_req;
    rd_any = |rd_req;
    if (&wr_req) wr_sel = FIXED ? 1'b0 : wr_prio;
    else         wr_sel = wr_req[1];
    if (&rd_req) rd_sel = FIXED ? 1'b0 : rd_prio;
    else         rd_sel = rd_req[1];
    // A be=0 write changes nothing, so the read may proceed alongside it
    collide = wr_any && rd_any && (be[wr_sel] != 4'h0) &&
              (addr[wr_sel] == addr[rd_sel]);
    rd_go   = rd_any && !collide;
    wr_gnt  = '0;
    rd_gnt  = '0;
    if (wr_any) wr_gnt[wr_sel] = 1'b1;
    if (rd_go)  rd_gnt[rd_sel] = 1'b1;
  end

  // Drive the RAM ports from the winners, zero when a port is idle
  always_comb begin
    bus.bram_addra = '0;
    bus.bram_dina  = '0;
    bus.bram_wea   = '0;
    bus.bram_addrb = '0;
    if (wr_any) begin
      bus.bram_addra = addr[wr_sel];
      bus.bram_dina  = wdata[wr_sel];
      bus.bram_wea   = be[wr_sel];
    end
    if (rd_go) bus.bram_addrb = addr[rd_sel];
  end

  assign bus.m0_gnt    = wr_gnt[0] | rd_gnt[0];
  assign bus.m1_gnt    = wr_gnt[1] | rd_gnt[1];
  assign bus.m0_rvalid = rvalid[0];
  assign bus.m1_rvalid = rvalid[1];
  assign bus.m0_rdata  = rdata[0];
  assign bus.m1_rdata  = rdata[1];

  // Round-robin pointers move only on contention, to the loser
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_prio <= 1'b0;
      rd_prio <= 1'b0;
    end else begin
      if (!FIXED && (&wr_req)) wr_prio <= ~wr_sel;
      if (!FIXED && (&rd_req)) rd_prio <= ~rd_sel;
    end
  end

  // Track the read issued this cycle; RAM data lands next cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rd_owner <= 2'b00;
    else          rd_owner <= {rd_go & rd_sel, rd_go};
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural RAM, shadow memory, per-master
// expected-read queues checked when rvalid appears.
module tb_bram_port_arbiter;
  logic HCLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 HCLK = ~HCLK;

  bram_port_arbiter_if #(.ADDR_WIDTH(12)) bus0 ();
  bram_port_arbiter_if #(.ADDR_WIDTH(12)) bus1 ();

  bram_port_arbiter #(.ADDR_WIDTH(12), .PRIO_MODE(0)) dut0 (
    .HCLK(HCLK), .HRESETn(rst_n), .bus(bus0));
  bram_port_arbiter #(.ADDR_WIDTH(12), .PRIO_MODE(1)) dut1 (
    .HCLK(HCLK), .HRESETn(rst_n), .bus(bus1));

  // Read-first RAM with byte write enables and registered output
  logic [31:0] ram [0:4095];
  always @(posedge HCLK) begin
    for (int b = 0; b < 4; b++)
      if (bus0.bram_wea[b]) ram[bus0.bram_addra][8*b +: 8] <= bus0.bram_dina[8*b +: 8];
    bus0.bram_doutb <= ram[bus0.bram_addrb];
  end
  assign bus1.bram_doutb = 32'h0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  always @(posedge HCLK) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [31:0] shadow [bit [11:0]];

  task automatic wr_shadow(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    if (!shadow.exists(a)) shadow[a] = 32'h0;
    for (int b = 0; b < 4; b++)
      if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
  endtask

  // Scoreboard: each rvalid must match the oldest expected read, on its due cycle
  always @(negedge HCLK) begin
    if (bus0.m0_rvalid) begin
      if (q0.size() == 0) chk("m0_rvalid_spurious", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("m0_rdata", bus0.m0_rdata, e0.data);
        chk("m0_rvalid_cycle", cyc_n, e0.due);
      end
    end
    if (bus0.m1_rvalid) begin
      if (q1.size() == 0) chk("m1_rvalid_spurious", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("m1_rdata", bus0.m1_rdata, e1.data);
        chk("m1_rvalid_cycle", cyc_n, e1.due);
      end
    end
  end

  // Issue one request per master (either optional), wait for both grants.
  // Called and returns at posedge+1.
  task automatic run_pair(
    input logic v0, input logic we0, input logic [3:0] be0, input logic [11:0] a0, input logic [31:0] d0,
    input logic v1, input logic we1, input logic [3:0] be1, input logic [11:0] a1, input logic [31:0] d1,
    output int g0, output int g1, output logic [3:0] wea_at);
    logic p0, p1;
    p0 = v0; p1 = v1; g0 = -1; g1 = -1; wea_at = '0;
    bus0.m0_req = v0; bus0.m0_we = we0; bus0.m0_be = be0; bus0.m0_addr = a0; bus0.m0_wdata = d0;
    bus0.m1_req = v1; bus0.m1_we = we1; bus0.m1_be = be1; bus0.m1_addr = a1; bus0.m1_wdata = d1;
    for (int k = 0; k < 8 && (p0 || p1); k++) begin
      @(negedge HCLK);
      if (p0 && bus0.m0_gnt && we0) begin
        wr_shadow(a0, be0, d0); g0 = cyc_n; wea_at = bus0.bram_wea; p0 = 1'b0;
      end
      if (p1 && bus0.m1_gnt && we1) begin
        wr_shadow(a1, be1, d1); g1 = cyc_n; wea_at = bus0.bram_wea; p1 = 1'b0;
      end
      if (p0 && bus0.m0_gnt && !we0) begin
        q0.push_back(exp_t'{shadow[a0], cyc_n + 1}); g0 = cyc_n; p0 = 1'b0;
      end
      if (p1 && bus0.m1_gnt && !we1) begin
        q1.push_back(exp_t'{shadow[a1], cyc_n + 1}); g1 = cyc_n; p1 = 1'b0;
      end
      @(posedge HCLK); #1;
      if (!p0) bus0.m0_req = 1'b0;
      if (!p1) bus0.m1_req = 1'b0;
    end
    if (p0 || p1) begin
      chk("grant_timeout", 1, 0);
      bus0.m0_req = 1'b0; bus0.m1_req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  int g0, g1;
  logic [3:0] wa;

  initial begin
    bus0.m0_req = 0; bus0.m0_we = 0; bus0.m0_be = 0; bus0.m0_addr = 0; bus0.m0_wdata = 0;
    bus0.m1_req = 0; bus0.m1_we = 0; bus0.m1_be = 0; bus0.m1_addr = 0; bus0.m1_wdata = 0;
    bus1.m0_req = 0; bus1.m0_we = 0; bus1.m0_be = 0; bus1.m0_addr = 0; bus1.m0_wdata = 0;
    bus1.m1_req = 0; bus1.m1_we = 0; bus1.m1_be = 0; bus1.m1_addr = 0; bus1.m1_wdata = 0;

    // Reset state, idle outputs
    repeat (2) @(negedge HCLK);
    chk("rst_m0_rvalid", bus0.m0_rvalid, 0);
    chk("rst_m1_rvalid", bus0.m1_rvalid, 0);
    chk("rst_gnt", {bus0.m0_gnt, bus0.m1_gnt}, 0);
    chk("rst_bram_a", {bus0.bram_addra, bus0.bram_dina, bus0.bram_wea}, 0);
    chk("rst_bram_b", bus0.bram_addrb, 0);
    rst_n = 1'b1;
    idle(1);

    // Write then read back from the other master
    run_pair(1, 1, 4'hF, 12'h010, 32'hDEADBEEF, 0, 0, 0, 0, 0, g0, g1, wa);
    chk("w010_wea", wa, 4'hF);
    run_pair(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1, wa); // no-op, nothing pending
    run_pair(0, 0, 0, 0, 0, 1, 0, 0, 12'h010, 0, g0, g1, wa);
    idle(2);

    // Preloads
    run_pair(1, 1, 4'hF, 12'h020, 32'h11111111, 0, 0, 0, 0, 0, g0, g1, wa);
    run_pair(1, 1, 4'hF, 12'h021, 32'h22222222, 0, 0, 0, 0, 0, g0, g1, wa);
    run_pair(1, 1, 4'hF, 12'h030, 32'h12345678, 0, 0, 0, 0, 0, g0, g1, wa);
    idle(1);

    // Continuous contended reads alternate starting with m0
    bus0.m0_req = 1; bus0.m0_we = 0; bus0.m0_addr = 12'h010;
    bus0.m1_req = 1; bus0.m1_we = 0; bus0.m1_addr = 12'h020;
    for (int k = 0; k < 6; k++) begin
      @(negedge HCLK);
      chk("rr_m0_gnt", bus0.m0_gnt, (k % 2) == 0);
      chk("rr_m1_gnt", bus0.m1_gnt, (k % 2) == 1);
      if (bus0.m0_gnt) q0.push_back(exp_t'{shadow[12'h010], cyc_n + 1});
      if (bus0.m1_gnt) q1.push_back(exp_t'{shadow[12'h020], cyc_n + 1});
      @(posedge HCLK); #1;
    end
    bus0.m0_req = 0; bus0.m1_req = 0;
    idle(2);

    // Continuous contended writes alternate starting with m0
    bus0.m0_req = 1; bus0.m0_we = 1; bus0.m0_be = 4'hF; bus0.m0_addr = 12'h040; bus0.m0_wdata = 32'hA0A0A0A0;
    bus0.m1_req = 1; bus0.m1_we = 1; bus0.m1_be = 4'hF; bus0.m1_addr = 12'h041; bus0.m1_wdata = 32'hB1B1B1B1;
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      chk("rrw_m0_gnt", bus0.m0_gnt, (k % 2) == 0);
      chk("rrw_m1_gnt", bus0.m1_gnt, (k % 2) == 1);
      chk("rrw_addra", bus0.bram_addra, (k % 2) == 0 ? 12'h040 : 12'h041);
      if (bus0.m0_gnt) wr_shadow(12'h040, 4'hF, 32'hA0A0A0A0);
      if (bus0.m1_gnt) wr_shadow(12'h041, 4'hF, 32'hB1B1B1B1);
      @(posedge HCLK); #1;
    end
    bus0.m0_req = 0; bus0.m1_req = 0;
    idle(1);

    // Collision: partial write and read of the same word, read stalls one cycle
    run_pair(1, 1, 4'b0011, 12'h020, 32'h0000ABCD, 1, 0, 0, 12'h020, 0, g0, g1, wa);
    chk("coll_stall", g1 - g0, 1);
    idle(2);
    run_pair(0, 0, 0, 0, 0, 1, 0, 0, 12'h040, 0, g0, g1, wa);
    run_pair(0, 0, 0, 0, 0, 1, 0, 0, 12'h041, 0, g0, g1, wa);
    // Different word: both in the same cycle
    run_pair(1, 1, 4'b0011, 12'h020, 32'h0000ABCD, 1, 0, 0, 12'h021, 0, g0, g1, wa);
    chk("mixed_same_cycle", g1 - g0, 0);
    idle(2);
    // be=0 write never stalls and leaves old data
    run_pair(1, 1, 4'h0, 12'h030, 32'hFFFFFFFF, 1, 0, 0, 12'h030, 0, g0, g1, wa);
    chk("be0_same_cycle", g1 - g0, 0);
    chk("be0_wea", wa, 4'h0);
    idle(2);

    // Move both pointers to m1
    run_pair(1, 0, 0, 12'h010, 0, 1, 0, 0, 12'h020, 0, g0, g1, wa);
    chk("pre_rd_order", g1 - g0, 1);
    run_pair(1, 1, 4'hF, 12'h050, 32'h50505050, 1, 1, 4'hF, 12'h051, 32'h51515151, g0, g1, wa);
    chk("pre_wr_order", g1 - g0, 1);
    idle(2);

    // Reset with a read in flight
    bus0.m0_req = 1; bus0.m0_we = 0; bus0.m0_addr = 12'h010;
    @(negedge HCLK);
    chk("rst_rd_gnt", bus0.m0_gnt, 1);
    #1 rst_n = 1'b0;
    bus0.m0_req = 0;
    @(posedge HCLK); #1;
    chk("rst_drop_rvalid", {bus0.m0_rvalid, bus0.m1_rvalid}, 0);
    @(negedge HCLK);
    chk("rst_drop_rvalid2", bus0.m0_rvalid, 0);
    rst_n = 1'b1;
    idle(1);
    // Pointers back at m0: m1 would win if they were not
    run_pair(1, 0, 0, 12'h010, 0, 1, 0, 0, 12'h020, 0, g0, g1, wa);
    chk("post_rst_rd_order", g1 - g0, 1);
    run_pair(1, 1, 4'hF, 12'h052, 32'h52525252, 1, 1, 4'hF, 12'h053, 32'h53535353, g0, g1, wa);
    chk("post_rst_wr_order", g1 - g0, 1);
    run_pair(1, 0, 0, 12'h052, 0, 0, 0, 0, 0, 0, g0, g1, wa);
    idle(2);

    // Fixed priority instance: m0 wins every cycle while it requests
    bus1.m0_req = 1; bus1.m0_we = 1; bus1.m0_be = 4'hF; bus1.m0_addr = 12'h060; bus1.m0_wdata = 32'h6;
    bus1.m1_req = 1; bus1.m1_we = 1; bus1.m1_be = 4'hF; bus1.m1_addr = 12'h061; bus1.m1_wdata = 32'h7;
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      chk("fix_m0_gnt", bus1.m0_gnt, 1);
      chk("fix_m1_gnt", bus1.m1_gnt, 0);
      chk("fix_addra", bus1.bram_addra, 12'h060);
      @(posedge HCLK); #1;
    end
    bus1.m0_req = 0;
    @(negedge HCLK);
    chk("fix_m1_after", bus1.m1_gnt, 1);
    @(posedge HCLK); #1;
    bus1.m1_req = 0;

    idle(3);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
